// File: rtl/sequence_generator_serial.sv
// Serial pattern transmitter.
// Sends the low `len` bits of a latched pattern MSB-first, one bit per clock
// where bit_en is high, optionally repeating the field back-to-back.
// The repetition-count port is named repeat_num because `repeat` is a reserved
// word in SystemVerilog.
module sequence_generator_serial #(
    parameter int PATTERN_W = 8,
    parameter int LEN_W     = 4,
    parameter int REP_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     len,
    input  logic [REP_W-1:0]     repeat_num,
    input  logic                 bit_en,
    input  logic                 abort,
    output logic                 data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);

    state_t               state;
    logic [PATTERN_W-1:0] pat_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     idx;
    logic [REP_W-1:0]     rep_cnt;

    logic [LEN_W-1:0]     len_clamped;
    logic                 cur_bit;

    // Requested lengths beyond the pattern width are limited to the full pattern.
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    // A one-hot mask selects the bit at idx; this avoids an index of mismatched width.
    assign cur_bit = |(pat_q & ({{(PATTERN_W-1){1'b0}}, 1'b1} << idx));

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign state_out = state;

    // Control FSM plus the shift datapath; all outputs except busy/done/state_out are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            rep_cnt    <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_valid <= 1'b0;
                    if (start) begin
                        if (len_clamped == '0) begin
                            state <= DONE;
                        end else begin
                            pat_q   <= pattern;
                            len_q   <= len_clamped;
                            idx     <= len_clamped - LEN_W'(1);
                            rep_cnt <= repeat_num;
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (bit_en) begin
                        data_out   <= cur_bit;
                        data_valid <= 1'b1;
                        if (idx != '0) begin
                            idx <= idx - LEN_W'(1);
                        end else if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - REP_W'(1);
                            idx     <= len_q - LEN_W'(1);
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        data_valid <= 1'b0;
                    end
                end
                DONE: begin
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
